// File: rtl/sobel_stream.sv
// sobel_stream
//   Streaming 3x3 Sobel operator over a raster pixel stream. Two line buffers
//   plus a 3x3 shift window build the neighbourhood; a 3-stage pipeline
//   produces |Gx|+|Gy| saturated to DATA_W bits, or a binary edge map when
//   mode is set. One result is emitted per interior pixel (borders dropped).
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data / in_sof valid this cycle
//   in_data   : unsigned pixel, raster order
//   in_sof    : first pixel (0,0) of a frame, qualified by in_valid
//   mode      : 0 = saturated magnitude, 1 = binary threshold
//   thresh    : threshold used in mode 1 (mag >= thresh -> all ones)
//   out_valid : single-cycle pulse per result
//   out_data  : result pixel
//   out_sof   : high with the result for centre (1,1)
module sobel_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              mode,
    input  logic [DATA_W-1:0] thresh,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW    = DATA_W + 3;   // signed gradient width
    localparam int MW    = DATA_W + 4;   // unsigned magnitude width

    // ------------------------------------------------------------------
    // Frame position tracking
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             active;

    logic             accept;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             last_col;
    logic             last_row;

    // in_sof forces the current pixel to (0,0), whether the frame was idle,
    // mid-way, or exactly at its final pixel.
    assign accept   = in_valid && (in_sof || active);
    assign cur_col  = in_sof ? '0 : col;
    assign cur_row  = in_sof ? '0 : row;
    assign last_col = (cur_col == COL_W'(IMG_W - 1));
    assign last_row = (cur_row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            active <= 1'b0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row    <= '0;
                    active <= 1'b0;
                end else begin
                    row    <= cur_row + ROW_W'(1);
                    active <= 1'b1;
                end
            end else begin
                col    <= cur_col + COL_W'(1);
                row    <= cur_row;
                active <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: line buffers and 3x3 window
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] lb0 [IMG_W];   // row r-1
    logic [DATA_W-1:0] lb1 [IMG_W];   // row r-2
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] win [9];       // p0..p8 row-major, p8 = newest pixel

    // Read is combinational so the column enters the window in the same
    // cycle the pixel is accepted, keeping stage 1 a single register.
    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[cur_col] <= lb0_rd;
            lb0[cur_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_data;
        end
    end

    logic v1, s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            v1 <= accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            s1 <= accept && (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gradients
    // ------------------------------------------------------------------
    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return GW'(p);
    endfunction

    logic [GW-1:0] gx_c, gy_c, gx_q, gy_q;
    logic          v2, s2;

    // Modulo-2^GW arithmetic yields the two's-complement signed result.
    always_comb begin
        gx_c = (ext(win[2]) + (ext(win[5]) << 1) + ext(win[8]))
             - (ext(win[0]) + (ext(win[3]) << 1) + ext(win[6]));
        gy_c = (ext(win[6]) + (ext(win[7]) << 1) + ext(win[8]))
             - (ext(win[0]) + (ext(win[1]) << 1) + ext(win[2]));
    end

    always_ff @(posedge clk) begin
        gx_q <= gx_c;
        gy_q <= gy_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            v2 <= v1;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, saturation / threshold
    // ------------------------------------------------------------------
    logic [GW-1:0]     abs_x, abs_y;
    logic [MW-1:0]     mag;
    logic [DATA_W-1:0] sat, thr, res;

    always_comb begin
        abs_x = gx_q[GW-1] ? (GW'(0) - gx_q) : gx_q;
        abs_y = gy_q[GW-1] ? (GW'(0) - gy_q) : gy_q;
        mag   = MW'(abs_x) + MW'(abs_y);
        sat   = (mag > MW'({DATA_W{1'b1}})) ? '1 : mag[DATA_W-1:0];
        thr   = (mag >= MW'(thresh)) ? '1 : '0;
        res   = mode ? thr : sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v2;
            out_sof   <= s2;
            if (v2) begin
                out_data <= res;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream
//   Directed bench for sobel_stream with a 5x4 image. Results are collected
//   by a negedge monitor and compared against hand-computed values and
//   against the drive cycle of each completing pixel plus three.
module tb_sobel_stream;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_sof   = 1'b0;
    logic          mode     = 1'b0;
    logic [DW-1:0] thresh   = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof;

    sobel_stream #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .mode      (mode),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int got_d[$];
    int got_s[$];
    int got_t[$];
    int exp_t[$];

    always @(negedge clk) begin
        if (out_valid) begin
            got_d.push_back(int'(out_data));
            got_s.push_back(int'(out_sof));
            got_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        if (kind == 0) return (r == 0) ? 0 : 62;
        return (c < 2) ? 0 : 200;
    endfunction

    task automatic drive(input int d, input bit sof, input bit v);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = DW'(d);
    endtask

    task automatic clear_q();
        got_d.delete();
        got_s.delete();
        got_t.delete();
        exp_t.delete();
    endtask

    task automatic flush();
        repeat (6) drive(0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int kind, input bit gapped, input bit with_sof);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(pix(kind, r, c), with_sof && r == 0 && c == 0, 1'b1);
                if (r >= 2 && c >= 2) exp_t.push_back(cyc + 3);
                if (gapped) drive(0, 1'b0, 1'b0);
            end
        end
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic check_frame(input string name, input int e [6]);
        chk({name, " count"}, got_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s data%0d", name, i),
                (i < got_d.size()) ? got_d[i] : -1, e[i]);
            chk($sformatf("%s sof%0d", name, i),
                (i < got_s.size()) ? got_s[i] : -1, (i == 0) ? 1 : 0);
            chk($sformatf("%s time%0d", name, i),
                (i < got_t.size()) ? got_t[i] : -1,
                (i < exp_t.size()) ? exp_t[i] : -2);
        end
        clear_q();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_sof", int'(out_sof), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pixels before any in_sof are discarded
        for (int i = 0; i < 12; i++) drive(62 + i, 1'b0, 1'b1);
        flush();
        chk("pre-sof count", got_d.size(), 0);
        clear_q();

        // 1. Horizontal edge, mode 0
        mode = 1'b0;
        frame(0, 1'b0, 1'b1);
        flush();
        check_frame("t1", '{248, 248, 248, 0, 0, 0});

        // 2. Vertical edge, mode 0
        frame(1, 1'b0, 1'b1);
        flush();
        check_frame("t2", '{255, 255, 0, 255, 255, 0});

        // 3. Threshold mode
        mode   = 1'b1;
        thresh = 8'd100;
        frame(0, 1'b0, 1'b1);
        flush();
        check_frame("t3a", '{255, 255, 255, 0, 0, 0});
        thresh = 8'd249;
        frame(0, 1'b0, 1'b1);
        flush();
        check_frame("t3b", '{0, 0, 0, 0, 0, 0});
        mode = 1'b0;

        // 4. Gapped input
        frame(0, 1'b1, 1'b1);
        flush();
        check_frame("t4", '{248, 248, 248, 0, 0, 0});

        // 5. Reset mid-frame with results in flight
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                drive(pix(0, r, c), r == 0 && c == 0, 1'b1);
        @(posedge clk);
        #1;
        chk("t5 pre valid", int'(out_valid), 1);
        chk("t5 pre data", int'(out_data), 248);
        rst_n = 1'b0;
        #1;
        chk("t5 rst valid", int'(out_valid), 0);
        chk("t5 rst data", int'(out_data), 0);
        chk("t5 rst sof", int'(out_sof), 0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        clear_q();
        frame(0, 1'b0, 1'b0);
        flush();
        chk("t5 no-sof count", got_d.size(), 0);
        clear_q();
        frame(0, 1'b0, 1'b1);
        flush();
        check_frame("t5", '{248, 248, 248, 0, 0, 0});

        // 6. Restart at row 2 col 1 of an old frame, then extra pixels
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c < 1) drive(pix(1, r, c), r == 0 && c == 0, 1'b1);
        clear_q();
        frame(0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(62, 1'b0, 1'b1);
        flush();
        check_frame("t6", '{248, 248, 248, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
